mc_controller: RTL

//  Multi-cycle main control FSM for the MIPS datapath (PC, IM, GRF, EXT, ALU, DM, mult/div unit).

---
 rtl/mc_controller.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS main control FSM with mult/div handshake
module mc_controller #(
   parameter int MD_MAX_WAIT = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       cmp_eq,
   input  logic       md_busy,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic       ext_sign,
   output logic       alu_src_b,
   output logic [3:0] alu_op,
   output logic       mem_we,
   output logic       reg_we,
   output logic [1:0] reg_dst,
   output logic [1:0] wd_sel,
   output logic       md_start,
   output logic       md_op,
   output logic       instr_done,
   output logic       illegal,
   output logic       md_timeout
);

   localparam int CW = (MD_MAX_WAIT > 1) ? $clog2(MD_MAX_WAIT) : 1;
   localparam logic [CW-1:0] WAIT_LAST = CW'(MD_MAX_WAIT - 1);

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2b;

   localparam logic [5:0] FN_NOP  = 6'h00;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_MFHI = 6'h10;
   localparam logic [5:0] FN_MFLO = 6'h12;
   localparam logic [5:0] FN_MULT = 6'h18;
   localparam logic [5:0] FN_DIV  = 6'h1a;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;

   typedef enum logic [3:0] {
      sFetch, sDecode, sExec, sRwb, sIwb, sMaddr, sMrd, sMwb, sMwr,
      sBr, sJmp, sMdst, sMdwait
   } state_t;

   state_t        state;
   logic [CW-1:0] mdCount;
   logic          isRAlu, isImm, isMem, isBeq, isJump, isMd, isMf, isNop;
   logic          isLegal;
   logic          mdLast;

   assign isLegal = isRAlu | isImm | isMem | isBeq | isJump | isMd | isMf | isNop;
   assign mdLast  = (mdCount == WAIT_LAST);

   // Instruction class decode from the IR opcode/function fields
   always_comb begin
      isRAlu = 1'b0;
      isImm  = 1'b0;
      isMem  = 1'b0;
      isBeq  = 1'b0;
      isJump = 1'b0;
      isMd   = 1'b0;
      isMf   = 1'b0;
      isNop  = 1'b0;
      case (op)
         OP_SPECIAL: begin
            case (func)
               FN_ADDU, FN_SUBU: isRAlu = 1'b1;
               FN_JR:            isJump = 1'b1;
               FN_MULT, FN_DIV:  isMd   = 1'b1;
               FN_MFHI, FN_MFLO: isMf   = 1'b1;
               FN_NOP:           isNop  = 1'b1;
               default: ;
            endcase
         end
         OP_ORI, OP_LUI: isImm  = 1'b1;
         OP_LW, OP_SW:   isMem  = 1'b1;
         OP_BEQ:         isBeq  = 1'b1;
         OP_J, OP_JAL:   isJump = 1'b1;
         default: ;
      endcase
   end

   // State sequencing and mult/div wait counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= sFetch;
         mdCount <= '0;
      end else begin
         case (state)
            sFetch:  state <= sDecode;
            sDecode: begin
               if (isRAlu || isImm)  state <= sExec;
               else if (isMem)       state <= sMaddr;
               else if (isBeq)       state <= sBr;
               else if (isJump)      state <= sJmp;
               else if (isMd)        state <= sMdst;
               else if (isMf)        state <= sRwb;
               else                  state <= sFetch;
            end
            sExec:   state <= isImm ? sIwb : sRwb;
            sMaddr:  state <= (op == OP_LW) ? sMrd : sMwr;
            sMrd:    state <= sMwb;
            sMdst: begin
               state   <= sMdwait;
               mdCount <= '0;
            end
            sMdwait: begin
               if (!md_busy || mdLast) state <= sFetch;
               else                    mdCount <= mdCount + 1'b1;
            end
            default: state <= sFetch;
         endcase
      end
   end

   // Datapath strobes decoded from state and IR fields, forced low during reset
   always_comb begin
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 2'd0;
      ext_sign   = 1'b0;
      alu_src_b  = 1'b0;
      alu_op     = 4'd0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 2'd0;
      wd_sel     = 2'd0;
      md_start   = 1'b0;
      md_op      = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      md_timeout = 1'b0;
      if (!reset) begin
         case (state)
            sFetch: begin
               ir_we = 1'b1;
               pc_we = 1'b1;
            end
            sDecode: begin
               if (isNop) begin
                  instr_done = 1'b1;
               end else if (!isLegal) begin
                  illegal    = 1'b1;
                  instr_done = 1'b1;
               end
            end
            sExec: begin
               alu_src_b = isImm;
               case (op)
                  OP_ORI:  alu_op = 4'd2;
                  OP_LUI:  alu_op = 4'd3;
                  default: alu_op = (func == FN_SUBU) ? 4'd1 : 4'd0;
               endcase
            end
            sRwb: begin
               reg_we     = 1'b1;
               reg_dst    = 2'd1;
               wd_sel     = isMf ? 2'd3 : 2'd0;
               instr_done = 1'b1;
            end
            sIwb: begin
               reg_we     = 1'b1;
               instr_done = 1'b1;
            end
            sMaddr: begin
               alu_src_b = 1'b1;
               ext_sign  = 1'b1;
            end
            sMwb: begin
               reg_we     = 1'b1;
               wd_sel     = 2'd1;
               instr_done = 1'b1;
            end
            sMwr: begin
               mem_we     = 1'b1;
               instr_done = 1'b1;
            end
            sBr: begin
               pc_src     = 2'd1;
               ext_sign   = 1'b1;
               pc_we      = cmp_eq;
               instr_done = 1'b1;
            end
            sJmp: begin
               pc_we  = 1'b1;
               pc_src = (op == OP_SPECIAL) ? 2'd3 : 2'd2;
               if (op == OP_JAL) begin
                  reg_we  = 1'b1;
                  reg_dst = 2'd2;
                  wd_sel  = 2'd2;
               end
               instr_done = 1'b1;
            end
            sMdst: begin
               md_start = 1'b1;
               md_op    = (func == FN_DIV);
            end
            sMdwait: begin
               if (!md_busy) begin
                  instr_done = 1'b1;
               end else if (mdLast) begin
                  md_timeout = 1'b1;
                  instr_done = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
